// File: rtl/matmul_pkg.sv
// Shared types and helpers for the lane-multiplexed matrix multiplier.
// The accumulator width and the output saturation rule are defined once here.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Accumulators are widened to this before clamping; must exceed any ACC_W used.
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  clamped;
    wide_t value;
  } sat_t;

  function automatic int acc_width(int data_w, int out_w, int k);
    int w;
    w = 2 * data_w + $clog2(k + 1);
    return ((w > out_w) ? w : out_w) + 1;
  endfunction

  function automatic sat_t sat_clamp(wide_t acc, int out_w);
    wide_t one;
    wide_t hi;
    wide_t lo;
    sat_t  r;
    one = wide_t'(1);
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -(one <<< (out_w - 1));
    r.clamped = 1'b0;
    r.value   = acc;
    if (acc > hi) begin
      r.clamped = 1'b1;
      r.value   = hi;
    end else if (acc < lo) begin
      r.clamped = 1'b1;
      r.value   = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane; acc is the value the register takes on this edge,
// so the owner can use the completed dot product in the same cycle as the last product.
module mac_lane #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic signed [ACC_W-1:0]  seed,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [ACC_W-1:0]    acc_reg;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;
  assign acc  = (clear ? seed : acc_reg) + ACC_W'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc;
    end
  end

endmodule

// File: rtl/matmul_lane_engine.sv
// Time-multiplexed signed matrix multiplier: LANES MAC lanes sweep the M*N outputs in passes
// of K cycles, writing saturated results into a persistent C register file.
module matmul_lane_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int M      = 2,
  parameter int K      = 3,
  parameter int N      = 4,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [M*K*DATA_W-1:0]     a_mat,
  input  logic [K*N*DATA_W-1:0]     b_mat,
  input  logic                      acc_mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [M*N*OUT_W-1:0]      c_mat,
  output logic                      sat_flag,
  output logic                      busy
);

  localparam int E     = M * N;
  localparam int P     = (E + LANES - 1) / LANES;
  localparam int ACC_W = acc_width(DATA_W, OUT_W, K);
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  state_t                  state_reg, state_next;
  logic [PW-1:0]           pass_reg;
  logic [KW-1:0]           k_reg;
  logic [M*K*DATA_W-1:0]   a_reg;
  logic [K*N*DATA_W-1:0]   b_reg;
  logic                    mode_reg;
  logic [M*N*OUT_W-1:0]    c_reg;
  logic                    sat_reg;
  logic                    last_k, last_pass;

  logic signed [DATA_W-1:0] lane_a    [LANES];
  logic signed [DATA_W-1:0] lane_b    [LANES];
  logic signed [ACC_W-1:0]  lane_seed [LANES];
  logic signed [ACC_W-1:0]  lane_acc  [LANES];
  logic [OUT_W-1:0]         lane_res  [LANES];
  sat_t                     lane_sat  [LANES];
  int                       lane_e    [LANES];
  logic [LANES-1:0]         lane_active;
  logic [LANES-1:0]         lane_clamp;

  assign last_k    = (k_reg == KW'(K - 1));
  assign last_pass = (pass_reg == PW'(P - 1));
  assign c_mat     = c_reg;
  assign sat_flag  = sat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == IDLE);
    out_valid  = (state_reg == DONE);
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:    if (in_valid) state_next = COMPUTE;
      COMPUTE: if (last_k && last_pass) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane l works on element pass*LANES+l; out-of-range lanes are parked on element 0.
  always_comb begin
    int e, i, j, kk;
    logic signed [OUT_W-1:0] c_prev;
    e = 0; i = 0; j = 0; kk = 0;
    c_prev = '0;
    for (int l = 0; l < LANES; l++) begin
      e = int'(pass_reg) * LANES + l;
      lane_active[l] = (e < E);
      if (e >= E) e = 0;
      lane_e[l] = e;
      i  = e / N;
      j  = e % N;
      kk = int'(k_reg);
      lane_a[l] = a_reg[(i*K + kk)*DATA_W +: DATA_W];
      lane_b[l] = b_reg[(kk*N + j)*DATA_W +: DATA_W];
      c_prev    = c_reg[e*OUT_W +: OUT_W];
      lane_seed[l] = mode_reg ? ACC_W'(c_prev) : '0;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_sat[l]   = sat_clamp(wide_t'(lane_acc[l]), OUT_W);
      lane_clamp[l] = lane_sat[l].clamped;
      lane_res[l]   = OUT_W'(lane_sat[l].value);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en    ((state_reg == COMPUTE) && lane_active[gi]),
      .clear (k_reg == '0),
      .seed  (lane_seed[gi]),
      .a     (lane_a[gi]),
      .b     (lane_b[gi]),
      .acc   (lane_acc[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_reg <= '0;
      k_reg    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      mode_reg <= 1'b0;
      c_reg    <= '0;
      sat_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a_mat;
            b_reg    <= b_mat;
            mode_reg <= acc_mode;
            sat_reg  <= 1'b0;
            pass_reg <= '0;
            k_reg    <= '0;
          end
        end
        COMPUTE: begin
          if (last_k) begin
            k_reg <= '0;
            for (int l = 0; l < LANES; l++) begin
              if (lane_active[l]) c_reg[lane_e[l]*OUT_W +: OUT_W] <= lane_res[l];
            end
            sat_reg <= sat_reg | (|(lane_clamp & lane_active));
            if (!last_pass) pass_reg <= pass_reg + PW'(1);
          end else begin
            k_reg <= k_reg + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_lane_engine.sv
// Directed bench: three engine instances (default, OUT_W=16, LANES=3) share operand buses
// and are exercised one at a time with hand-computed expected matrices.
module tb_matmul_lane_engine;

  localparam int DW = 16;

  logic         clk;
  logic         rst_n;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   busy;
  logic [2:0]   sat;
  logic [95:0]  a_mat;
  logic [191:0] b_mat;
  logic         acc_mode;
  logic         out_ready;
  logic [255:0] c0;
  logic [127:0] c1;
  logic [255:0] c2;

  int n_checks = 0;
  int n_fail   = 0;
  int aval [6];
  int bval [12];
  int expc [8];

  matmul_lane_engine #(.DATA_W(DW), .OUT_W(32), .M(2), .K(3), .N(4), .LANES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a_mat(a_mat), .b_mat(b_mat), .acc_mode(acc_mode), .out_valid(out_valid[0]),
    .out_ready(out_ready), .c_mat(c0), .sat_flag(sat[0]), .busy(busy[0])
  );

  matmul_lane_engine #(.DATA_W(DW), .OUT_W(16), .M(2), .K(3), .N(4), .LANES(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a_mat(a_mat), .b_mat(b_mat), .acc_mode(acc_mode), .out_valid(out_valid[1]),
    .out_ready(out_ready), .c_mat(c1), .sat_flag(sat[1]), .busy(busy[1])
  );

  matmul_lane_engine #(.DATA_W(DW), .OUT_W(32), .M(2), .K(3), .N(4), .LANES(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a_mat(a_mat), .b_mat(b_mat), .acc_mode(acc_mode), .out_valid(out_valid[2]),
    .out_ready(out_ready), .c_mat(c2), .sat_flag(sat[2]), .busy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint c_elem(input int sel, input int idx);
    logic signed [31:0] v;
    logic signed [15:0] h;
    case (sel)
      0:       v = c0[idx*32 +: 32];
      1:       begin h = c1[idx*16 +: 16]; v = 32'(h); end
      default: v = c2[idx*32 +: 32];
    endcase
    return longint'(v);
  endfunction

  task automatic load_mats();
    for (int i = 0; i < 6; i++)  a_mat[i*DW +: DW] = aval[i][DW-1:0];
    for (int i = 0; i < 12; i++) b_mat[i*DW +: DW] = bval[i][DW-1:0];
  endtask

  task automatic set_base();
    aval = '{1, 2, 3, 4, 5, 6};
    bval = '{1, 0, 0, 1,  0, 1, 0, 1,  0, 0, 1, 1};
    expc = '{1, 2, 3, 6,  4, 5, 6, 15};
  endtask

  task automatic start_job(input int sel, input logic mode);
    int guard;
    guard = 0;
    while (!in_ready[sel] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check_val("in_ready_before_job", longint'(in_ready[sel]), 1);
    @(negedge clk);
    load_mats();
    acc_mode      = mode;
    in_valid[sel] = 1'b1;
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    check_val("busy_after_capture", longint'(busy[sel]), 1);
  endtask

  // Cycles counted with the capture cycle as 0; out_valid is due in cycle P*K+1.
  task automatic wait_done(input int sel, output int lat);
    int cnt;
    cnt = 0;
    while (!out_valid[sel] && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    lat = cnt + 1;
  endtask

  task automatic check_c(input int sel, input string tag);
    for (int idx = 0; idx < 8; idx++)
      check_val($sformatf("%s_c%0d", tag, idx), c_elem(sel, idx), longint'(expc[idx]));
  endtask

  task automatic handshake(input int sel);
    @(negedge clk);
    check_val("in_ready_in_done", longint'(in_ready[sel]), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("out_valid_after_hs", longint'(out_valid[sel]), 0);
    check_val("in_ready_after_hs", longint'(in_ready[sel]), 1);
    check_val("busy_after_hs", longint'(busy[sel]), 0);
  endtask

  task automatic run_job(input int sel, input logic mode, input int exp_lat,
                         input int exp_sat, input string tag);
    int lat;
    start_job(sel, mode);
    wait_done(sel, lat);
    $display("job %s inst=%0d mode=%0d latency=%0d sat=%0d c0=%0d c7=%0d",
             tag, sel, mode, lat, sat[sel], c_elem(sel, 0), c_elem(sel, 7));
    check_val({tag, "_latency"}, longint'(lat), longint'(exp_lat));
    check_c(sel, tag);
    check_val({tag, "_sat"}, longint'(sat[sel]), longint'(exp_sat));
  endtask

  initial begin
    bit seen_ov;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    acc_mode  = 1'b0;
    a_mat     = '0;
    b_mat     = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_val($sformatf("rst_in_ready%0d", s), longint'(in_ready[s]), 1);
      check_val($sformatf("rst_out_valid%0d", s), longint'(out_valid[s]), 0);
      check_val($sformatf("rst_busy%0d", s), longint'(busy[s]), 0);
      check_val($sformatf("rst_sat%0d", s), longint'(sat[s]), 0);
    end
    check_val("rst_c0", longint'(|c0), 0);
    check_val("rst_c1", longint'(|c1), 0);
    check_val("rst_c2", longint'(|c2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain product, then accumulate the same product on top of it.
    set_base();
    run_job(0, 1'b0, 7, 0, "plain");
    handshake(0);
    for (int i = 0; i < 8; i++) expc[i] = 2 * expc[i];
    run_job(0, 1'b1, 7, 0, "accum");
    handshake(0);

    // Output back-pressure with a competing job offered on the input.
    set_base();
    run_job(0, 1'b0, 7, 0, "stall");
    @(negedge clk);
    aval = '{9, 9, 9, 9, 9, 9};
    load_mats();
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_val("stall_out_valid", longint'(out_valid[0]), 1);
      check_val("stall_in_ready", longint'(in_ready[0]), 0);
      check_val("stall_c0", c_elem(0, 0), 1);
      check_val("stall_c7", c_elem(0, 7), 15);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    handshake(0);
    check_c(0, "persist");

    // Saturation on the 16-bit output instance, then a clean job clears the flag.
    aval = '{32767, 32767, 32767, 32767, 32767, 32767};
    for (int i = 0; i < 12; i++) bval[i] = 32767;
    expc = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    run_job(1, 1'b0, 7, 1, "sat_hi");
    handshake(1);
    check_val("sat_hi_sticky", longint'(sat[1]), 1);
    aval = '{-32768, -32768, -32768, -32768, -32768, -32768};
    for (int i = 0; i < 8; i++) expc[i] = -32768;
    run_job(1, 1'b0, 7, 1, "sat_lo");
    handshake(1);
    set_base();
    run_job(1, 1'b0, 7, 0, "sat_clean");
    handshake(1);

    // Three lanes for eight elements: three passes.
    set_base();
    run_job(2, 1'b0, 10, 0, "lanes3");
    handshake(2);

    // Reset in the middle of a computation.
    set_base();
    start_job(0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_val("mid_busy", longint'(busy[0]), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_busy", longint'(busy[0]), 0);
    check_val("mid_rst_in_ready", longint'(in_ready[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_ov = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid[0]) seen_ov = 1'b1;
    end
    $display("job midreset inst=0 out_valid_seen=%0d", seen_ov);
    check_val("mid_no_out_valid", longint'(seen_ov), 0);
    check_val("mid_c_clear", longint'(|c0), 0);
    check_val("mid_in_ready", longint'(in_ready[0]), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
